// File: rtl/object_mem_arbiter_if.sv
// rtl/object_mem_arbiter_if.sv - requester-side bus of the object BRAM arbiter
// One bit / lane per requester: 0 = physics, 1 = detection writer, 2 = renderer.
interface object_mem_arbiter_if #(
  parameter int OBJ_WIDTH  = 103,
  parameter int ADDR_WIDTH = 10
) ();
  logic [2:0]                 req_in;
  logic [2:0]                 gnt_out;
  logic [2:0]                 yield_out;
  logic [2:0]                 acc_valid_in;
  logic [2:0]                 we_in;
  logic [2:0][ADDR_WIDTH-1:0] addr_in;
  logic [2:0][OBJ_WIDTH-1:0]  data_in;
  logic [2:0]                 rd_valid_out;
  logic [OBJ_WIDTH-1:0]       rd_data_out;

  modport master (
    output req_in, acc_valid_in, we_in, addr_in, data_in,
    input  gnt_out, yield_out, rd_valid_out, rd_data_out
  );

  modport slave (
    input  req_in, acc_valid_in, we_in, addr_in, data_in,
    output gnt_out, yield_out, rd_valid_out, rd_data_out
  );
endinterface

// File: rtl/object_mem_arbiter.sv
// rtl/object_mem_arbiter.sv - round-robin owner arbiter for the single object BRAM port
// Registers the winning owner's command and steers read data back through a tag pipeline.
module object_mem_arbiter #(
  parameter int OBJ_WIDTH    = 103,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int HOLD_LIMIT   = 256
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  object_mem_arbiter_if.slave   bus,
  output logic                  mem_en_out,
  output logic                  mem_we_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [OBJ_WIDTH-1:0]  mem_data_out,
  input  logic [OBJ_WIDTH-1:0]  mem_data_in
);

  localparam int CNT_W = $clog2(HOLD_LIMIT + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [2:0]       gnt;
  logic [2:0]       accept;
  logic [1:0]       acc_idx;
  logic             acc_any;
  logic [2:0]       yield_d, yield_q;

  // Stage 0 travels with the registered command; stage READ_LATENCY meets mem_data_in.
  logic [READ_LATENCY:0] tag_v;
  logic [1:0]            tag_id [READ_LATENCY+1];
  logic [OBJ_WIDTH-1:0]  rd_hold_q;

  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] pick;
    pick = 2'd0;
    case (last)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_in) begin
          state_d = S_GRANT;
          owner_d = rr_pick(bus.req_in, last_q);
          hold_d  = '0;
        end
      end
      default: begin
        if (bus.req_in[owner_q]) begin
          if (hold_q < CNT_W'(HOLD_LIMIT)) hold_d = hold_q + CNT_W'(1);
        end else begin
          // Hand over directly to the next waiter so the port never idles between owners.
          last_d = owner_q;
          hold_d = '0;
          if (|bus.req_in) owner_d = rr_pick(bus.req_in, owner_q);
          else             state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    gnt = 3'b000;
    if (state_q == S_GRANT) gnt[owner_q] = 1'b1;
    accept  = bus.acc_valid_in & gnt & bus.req_in;
    acc_any = |accept;
    acc_idx = 2'd0;
    if (accept[1]) acc_idx = 2'd1;
    if (accept[2]) acc_idx = 2'd2;
    yield_d = 3'b000;
    if ((state_q == S_GRANT) && bus.req_in[owner_q] &&
        (hold_q >= CNT_W'(HOLD_LIMIT)) && ((bus.req_in & ~gnt) != 3'b000))
      yield_d = gnt;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mem_en_out   <= 1'b0;
      mem_we_out   <= 1'b0;
      mem_addr_out <= '0;
      mem_data_out <= '0;
      yield_q      <= 3'b000;
      rd_hold_q    <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= 2'd0;
      end
    end else begin
      mem_en_out <= acc_any;
      mem_we_out <= acc_any & bus.we_in[acc_idx];
      if (acc_any) begin
        mem_addr_out <= bus.addr_in[acc_idx];
        mem_data_out <= bus.data_in[acc_idx];
      end
      yield_q   <= yield_d;
      rd_hold_q <= bus.rd_data_out;
      tag_v[0]  <= acc_any & ~bus.we_in[acc_idx];
      tag_id[0] <= acc_idx;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign bus.gnt_out      = gnt;
  assign bus.yield_out    = yield_q;
  assign bus.rd_valid_out = tag_v[READ_LATENCY] ? (3'b001 << tag_id[READ_LATENCY]) : 3'b000;
  assign bus.rd_data_out  = tag_v[READ_LATENCY] ? mem_data_in : rd_hold_q;

endmodule

// File: tb/tb_object_mem_arbiter.sv
// tb/tb_object_mem_arbiter.sv - self-checking bench for object_mem_arbiter
// Vector table, directed corner sequences, then random traffic against a reference model.
module tb_object_mem_arbiter;

  localparam int OW = 103;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int HL = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          mem_en_out, mem_we_out;
  logic [AW-1:0] mem_addr_out;
  logic [OW-1:0] mem_data_out, mem_data_in;

  object_mem_arbiter_if #(.OBJ_WIDTH(OW), .ADDR_WIDTH(AW)) bus ();

  object_mem_arbiter #(.OBJ_WIDTH(OW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .HOLD_LIMIT(HL)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .bus          (bus),
    .mem_en_out   (mem_en_out),
    .mem_we_out   (mem_we_out),
    .mem_addr_out (mem_addr_out),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [OW-1:0] init_word(input int a);
    return {32'(a * 32'h9E37_79B1), 32'(a + 7), ~32'(a), 7'(a)};
  endfunction

  // BRAM model with READ_LATENCY cycles from registered command to data; junk when idle.
  logic [OW-1:0] bram [1024];
  logic [OW-1:0] rd_pipe [RL];
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int a = 0; a < 1024; a++) bram[a] <= init_word(a);
    end else if (mem_en_out && mem_we_out) begin
      bram[mem_addr_out] <= mem_data_out;
    end
    if (mem_en_out && !mem_we_out) rd_pipe[0] <= bram[mem_addr_out];
    else rd_pipe[0] <= OW'({$urandom(), $urandom(), $urandom(), $urandom()});
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_in = rd_pipe[RL-1];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] req, input logic [2:0] acc, input logic [2:0] we,
                        input logic [AW-1:0] base);
    bus.req_in       = req;
    bus.acc_valid_in = acc;
    bus.we_in        = we;
    for (int k = 0; k < 3; k++) begin
      bus.addr_in[k] = base ^ (AW'(k) << 8);
      bus.data_in[k] = init_word(2000 + k);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gnt"}, bus.gnt_out, 0);
    chk({tag, ".yield"}, bus.yield_out, 0);
    chk({tag, ".rd_valid"}, bus.rd_valid_out, 0);
    chk({tag, ".rd_data"}, bus.rd_data_out, 0);
    chk({tag, ".mem_en"}, mem_en_out, 0);
    chk({tag, ".mem_we"}, mem_we_out, 0);
    chk({tag, ".mem_addr"}, mem_addr_out, 0);
    chk({tag, ".mem_data"}, mem_data_out, 0);
  endtask

  typedef struct {
    logic [2:0]    req, acc, we;
    logic [AW-1:0] base;
    logic [2:0]    e_gnt;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [2:0]    e_rv;
    logic [AW-1:0] e_rd_addr;
  } vec_t;
  vec_t vt [18];

  // Reference model state
  typedef struct { int due; int who; logic [OW-1:0] data; } ret_t;
  ret_t          rq [$];
  logic [OW-1:0] shadow [1024];
  int            m_owner, m_last, m_hold, cyc;
  logic          exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [OW-1:0] exp_wdata, last_rd;
  logic [2:0]    exp_yield;
  logic [2:0]    r_req, r_acc, r_we;
  logic [AW-1:0] r_addr [3];
  logic [OW-1:0] r_data [3];

  function automatic int pick(input logic [2:0] r, input int last);
    for (int i = 1; i <= 3; i++) if (r[(last + i) % 3]) return (last + i) % 3;
    return -1;
  endfunction

  task automatic model_reset();
    rq.delete();
    for (int a = 0; a < 1024; a++) shadow[a] = init_word(a);
    m_owner = -1; m_last = 2; m_hold = 0; cyc = 0;
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    exp_yield = 3'b000; last_rd = '0;
  endtask

  task automatic model_check();
    logic [2:0]    e_gnt, e_rv;
    logic [OW-1:0] e_data;
    e_gnt = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    e_rv = 3'b000;
    e_data = last_rd;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv = 3'b001 << rq[0].who;
      e_data = rq[0].data;
      last_rd = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rnd.gnt", bus.gnt_out, e_gnt);
    chk("rnd.yield", bus.yield_out, exp_yield);
    chk("rnd.mem_en", mem_en_out, exp_en);
    if (exp_en) begin
      chk("rnd.mem_we", mem_we_out, exp_we);
      chk("rnd.mem_addr", mem_addr_out, exp_addr);
      if (exp_we) chk("rnd.mem_data", mem_data_out, exp_wdata);
    end
    chk("rnd.rd_valid", bus.rd_valid_out, e_rv);
    chk("rnd.rd_data", bus.rd_data_out, e_data);
  endtask

  task automatic model_step();
    int  o;
    logic ok;
    o = m_owner;
    ok = (o >= 0) && r_req[o] && r_acc[o];
    exp_en = ok;
    if (ok) begin
      exp_we = r_we[o];
      exp_addr = r_addr[o];
      exp_wdata = r_data[o];
      if (r_we[o]) shadow[r_addr[o]] = r_data[o];
      else rq.push_back('{cyc + 1 + RL, o, shadow[r_addr[o]]});
    end
    exp_yield = 3'b000;
    if (o >= 0 && r_req[o] && m_hold >= HL && (r_req & ~(3'b001 << o)) != 3'b000)
      exp_yield = 3'b001 << o;
    if (o < 0) begin
      if (r_req != 3'b000) begin m_owner = pick(r_req, m_last); m_hold = 0; end
    end else if (r_req[o]) begin
      m_hold++;
    end else begin
      m_last = o;
      m_hold = 0;
      m_owner = (r_req != 3'b000) ? pick(r_req, o) : -1;
    end
    cyc++;
  endtask

  logic [2:0] y_req [9];
  logic [2:0] y_exp [9];

  initial begin
    vt[0]  = '{3'b111, 3'b000, 3'b000, 10'd0, 3'b000, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[1]  = '{3'b111, 3'b001, 3'b000, 10'd3, 3'b001, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[2]  = '{3'b110, 3'b000, 3'b000, 10'd0, 3'b001, 1'b1, 10'd3,   3'b000, 10'd0};
    vt[3]  = '{3'b110, 3'b010, 3'b000, 10'd4, 3'b010, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[4]  = '{3'b101, 3'b000, 3'b000, 10'd0, 3'b010, 1'b1, 10'd260, 3'b001, 10'd3};
    vt[5]  = '{3'b101, 3'b100, 3'b000, 10'd5, 3'b100, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[6]  = '{3'b001, 3'b000, 3'b000, 10'd0, 3'b100, 1'b1, 10'd517, 3'b010, 10'd260};
    vt[7]  = '{3'b001, 3'b001, 3'b000, 10'd6, 3'b001, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[8]  = '{3'b000, 3'b000, 3'b000, 10'd0, 3'b001, 1'b1, 10'd6,   3'b100, 10'd517};
    vt[9]  = '{3'b000, 3'b000, 3'b000, 10'd0, 3'b000, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[10] = '{3'b000, 3'b000, 3'b000, 10'd0, 3'b000, 1'b0, 10'd0,   3'b001, 10'd6};
    vt[11] = '{3'b010, 3'b000, 3'b000, 10'd0, 3'b000, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[12] = '{3'b010, 3'b001, 3'b000, 10'd9, 3'b010, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[13] = '{3'b010, 3'b001, 3'b000, 10'd9, 3'b010, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[14] = '{3'b000, 3'b010, 3'b000, 10'd9, 3'b010, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[15] = '{3'b000, 3'b000, 3'b000, 10'd0, 3'b000, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[16] = '{3'b000, 3'b000, 3'b000, 10'd0, 3'b000, 1'b0, 10'd0,   3'b000, 10'd0};
    vt[17] = '{3'b000, 3'b000, 3'b000, 10'd0, 3'b000, 1'b0, 10'd0,   3'b000, 10'd0};

    y_req = '{3'b100, 3'b100, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b100, 3'b000};
    y_exp = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000};

    sys_rst = 1'b1;
    set_in(3'b000, 3'b000, 3'b000, 10'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    chk_all_zero("reset");
    sys_rst = 1'b0;

    // Grant rotation, read returns, non-owner and release-cycle drops
    for (int i = 0; i < 18; i++) begin
      set_in(vt[i].req, vt[i].acc, vt[i].we, vt[i].base);
      @(negedge sys_clk);
      chk($sformatf("vec%0d.gnt", i), bus.gnt_out, vt[i].e_gnt);
      chk($sformatf("vec%0d.mem_en", i), mem_en_out, vt[i].e_en);
      if (vt[i].e_en) chk($sformatf("vec%0d.mem_addr", i), mem_addr_out, vt[i].e_addr);
      chk($sformatf("vec%0d.rd_valid", i), bus.rd_valid_out, vt[i].e_rv);
      if (vt[i].e_rv != 3'b000)
        chk($sformatf("vec%0d.rd_data", i), bus.rd_data_out, init_word(int'(vt[i].e_rd_addr)));
      chk($sformatf("vec%0d.yield", i), bus.yield_out, 3'b000);
      next_cycle();
    end

    // Owner 0 reads then releases to waiting 1; the return still reaches 0
    set_in(3'b011, 3'b000, 3'b000, 10'd0);
    next_cycle();
    set_in(3'b011, 3'b001, 3'b000, 10'd7);
    @(negedge sys_clk);
    chk("handoff.gnt0", bus.gnt_out, 3'b001);
    next_cycle();
    set_in(3'b010, 3'b000, 3'b000, 10'd0);
    @(negedge sys_clk);
    chk("handoff.mem_addr", mem_addr_out, 10'd7);
    next_cycle();
    @(negedge sys_clk);
    chk("handoff.gnt1", bus.gnt_out, 3'b010);
    next_cycle();
    set_in(3'b000, 3'b000, 3'b000, 10'd0);
    @(negedge sys_clk);
    chk("handoff.rd_valid", bus.rd_valid_out, 3'b001);
    chk("handoff.rd_data", bus.rd_data_out, init_word(7));
    next_cycle();
    next_cycle();

    // Owner 2 overstays while 0 waits
    for (int i = 0; i < 9; i++) begin
      set_in(y_req[i], 3'b000, 3'b000, 10'd0);
      @(negedge sys_clk);
      chk($sformatf("yield%0d", i), bus.yield_out, y_exp[i]);
      if (i > 0) chk($sformatf("yield%0d.gnt", i), bus.gnt_out, 3'b100);
      next_cycle();
    end
    @(negedge sys_clk);
    chk("yield.release_gnt", bus.gnt_out, 3'b000);
    next_cycle();

    // Reset with two reads in flight
    set_in(3'b001, 3'b000, 3'b000, 10'd0);
    next_cycle();
    set_in(3'b001, 3'b001, 3'b000, 10'd1);
    next_cycle();
    set_in(3'b001, 3'b001, 3'b000, 10'd2);
    next_cycle();
    set_in(3'b000, 3'b000, 3'b000, 10'd0);
    sys_rst = 1'b1;
    next_cycle();
    chk_all_zero("midrst");
    sys_rst = 1'b0;

    // Random traffic against the reference model
    model_reset();
    r_req = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 9) == 0) r_req[k] = ~r_req[k];
      r_acc = 3'($urandom_range(0, 7));
      r_we  = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        r_addr[k] = AW'($urandom_range(0, 31));
        r_data[k] = OW'({$urandom(), $urandom(), $urandom(), $urandom()});
      end
      bus.req_in = r_req;
      bus.acc_valid_in = r_acc;
      bus.we_in = r_we;
      for (int k = 0; k < 3; k++) begin
        bus.addr_in[k] = r_addr[k];
        bus.data_in[k] = r_data[k];
      end
      @(negedge sys_clk);
      model_check();
      model_step();
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
